// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit: HI/LO multiply-accumulate unit for mult/multu/madd/msub.
// Owns the architectural HI and LO registers and serves mthi/mtlo writes.
// Multiplication is iterative shift-add: 32 MUL cycles, then an ACC cycle.
// Optional build macro HILO_FAST_MUL_EN replaces the iterative multiplier
// with a combinational 32x32 product, so IDLE goes straight to ACC.
module hilo_mac_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WriteHi,
  input  logic        WriteLo,
  input  logic [31:0] Din,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    ACC  = 2'b10
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic [4:0]  count_q;
  logic        sign_q;
  logic [1:0]  op_q;

  logic [31:0] magA_d;
  logic [31:0] magB_d;
  logic        sign_d;
  logic [32:0] upperSum_d;
  logic [63:0] prodStep_d;
  logic [63:0] magnitude_d;
  logic [63:0] signedProd_d;
  logic [63:0] accResult_d;

  // Operand magnitudes and result sign, taken straight from the read ports
  // so they can be latched on the Start edge. |-2^31| = 2^31 still fits.
  always_comb begin
    magA_d = (Signed && A[31]) ? (32'd0 - A) : A;
    magB_d = (Signed && B[31]) ? (32'd0 - B) : B;
    sign_d = (A[31] ^ B[31]) & Signed;
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // 33 bits of the partial product, then shift the whole thing right by one.
  always_comb begin
    upperSum_d = {1'b0, prod_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    prodStep_d = {upperSum_d, prod_q[31:1]};
  end

  // Unsigned product magnitude: the iterated partial product, or a direct
  // multiply of the latched magnitudes in the fast build.
  always_comb begin
`ifdef HILO_FAST_MUL_EN
    magnitude_d = {32'd0, mcand_q} * {32'd0, mplier_q};
`else
    magnitude_d = prod_q;
`endif
  end

  // Apply the sign and fold the product into HI/LO according to the op.
  always_comb begin
    signedProd_d = sign_q ? (64'd0 - magnitude_d) : magnitude_d;
    case (op_q)
      OP_MULT: accResult_d = signedProd_d;
      OP_MADD: accResult_d = {hi_q, lo_q} + signedProd_d;
      OP_MSUB: accResult_d = {hi_q, lo_q} - signedProd_d;
      default: accResult_d = {hi_q, lo_q};
    endcase
  end

  // Control FSM plus all architectural and datapath registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      count_q  <= 5'd0;
      sign_q   <= 1'b0;
      op_q     <= OP_MULT;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start && (Op != OP_RSVD)) begin
            mcand_q  <= magA_d;
            mplier_q <= magB_d;
            sign_q   <= sign_d;
            op_q     <= Op;
            prod_q   <= 64'd0;
            count_q  <= 5'd0;
            busy_q   <= 1'b1;
`ifdef HILO_FAST_MUL_EN
            state_q  <= ACC;
`else
            state_q  <= MUL;
`endif
          end else if (!Start) begin
            if (WriteHi) hi_q <= Din;
            if (WriteLo) lo_q <= Din;
          end
        end
        MUL: begin
          prod_q   <= prodStep_d;
          mplier_q <= {1'b0, mplier_q[31:1]};
          count_q  <= count_q + 5'd1;
          if (count_q == 5'd31) state_q <= ACC;
        end
        ACC: begin
          hi_q    <= accResult_d[63:32];
          lo_q    <= accResult_d[31:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb_hilo_mac_unit: directed, table-driven bench for hilo_mac_unit.
// Honours HILO_FAST_MUL_EN for the expected Busy duration.
module tb_hilo_mac_unit;

`ifdef HILO_FAST_MUL_EN
  localparam int ExpBusy = 1;
`else
  localparam int ExpBusy = 33;
`endif

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        WriteHi;
  logic        WriteLo;
  logic [31:0] Din;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  int assertCount = 0;
  int failCount   = 0;

  hilo_mac_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Signed(Signed),
    .A(A), .B(B), .WriteHi(WriteHi), .WriteLo(WriteLo), .Din(Din),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] preHi;
    logic [31:0] preLo;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic directWrite(input logic [31:0] hiVal, input logic [31:0] loVal);
    @(negedge Clk);
    WriteHi = 1'b1; Din = hiVal;
    @(negedge Clk);
    WriteHi = 1'b0; WriteLo = 1'b1; Din = loVal;
    @(negedge Clk);
    WriteLo = 1'b0; Din = 32'd0;
  endtask

  // Issue one Start and observe 40 cycles after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               output int busyCnt, output int doneCnt,
                               output int overlapCnt);
    busyCnt = 0; doneCnt = 0; overlapCnt = 0;
    @(negedge Clk);
    Start = 1'b1; Op = op; Signed = sgn; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = 32'hDEAD_0000; B = 32'h0000_BEEF; Signed = ~sgn;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busyCnt++;
      if (Done) doneCnt++;
      if (Done && Busy) overlapCnt++;
      @(negedge Clk);
    end
  endtask

  initial begin
    int busyCnt, doneCnt, overlapCnt;

    vecs[0] = '{"smult_m3x7", 2'b00, 1'b1, 32'hFFFFFFFD, 32'd7,
                32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"umult_max", 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"madd_carry", 2'b01, 1'b1, 32'd1, 32'd1,
                32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[3] = '{"msub_borrow", 2'b10, 1'b1, 32'd2, 32'd3,
                32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[4] = '{"smult_minint", 2'b00, 1'b1, 32'h80000000, 32'h80000000,
                32'h0, 32'h0, 32'h40000000, 32'h00000000};
    vecs[5] = '{"smult_m1xm1", 2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h5, 32'h6, 32'h00000000, 32'h00000001};
    vecs[6] = '{"umadd_2p32", 2'b01, 1'b0, 32'h00010000, 32'h00010000,
                32'h12345678, 32'h9ABCDEF0, 32'h12345679, 32'h9ABCDEF0};
    vecs[7] = '{"smsub_neg", 2'b10, 1'b1, 32'hFFFFFFFF, 32'd5,
                32'h0, 32'h5, 32'h00000000, 32'h0000000A};
    vecs[8] = '{"mult_zero", 2'b00, 1'b0, 32'd0, 32'h1234,
                32'hAAAA, 32'hBBBB, 32'h00000000, 32'h00000000};
    vecs[9] = '{"umult_x2", 2'b00, 1'b0, 32'hFFFFFFFF, 32'd2,
                32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE};

    Rst = 1'b0; Start = 1'b0; Op = 2'b00; Signed = 1'b0; A = 32'd0; B = 32'd0;
    WriteHi = 1'b0; WriteLo = 1'b0; Din = 32'd0;

    // Asynchronous reset before any clock edge
    #2 Rst = 1'b1;
    #1;
    checkOutput("reset_hi", {32'd0, Hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, Lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_done", {63'd0, Done}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Direct writes, both at once
    @(negedge Clk);
    WriteHi = 1'b1; WriteLo = 1'b1; Din = 32'hCAFEF00D;
    @(negedge Clk);
    WriteHi = 1'b0; WriteLo = 1'b0;
    checkOutput("dual_write", {Hi, Lo}, {32'hCAFEF00D, 32'hCAFEF00D});

    // Reserved op is ignored and also blocks the direct write
    Start = 1'b1; Op = 2'b11; WriteHi = 1'b1; Din = 32'h0BAD0BAD;
    @(negedge Clk);
    Start = 1'b0; WriteHi = 1'b0;
    checkOutput("rsvd_busy", {63'd0, Busy}, 64'd0);
    checkOutput("rsvd_hilo", {Hi, Lo}, {32'hCAFEF00D, 32'hCAFEF00D});

    // Table-driven operations
    foreach (vecs[i]) begin
      directWrite(vecs[i].preHi, vecs[i].preLo);
      applyStimulus(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    busyCnt, doneCnt, overlapCnt);
      checkOutput({vecs[i].name, "_hilo"}, {Hi, Lo}, {vecs[i].expHi, vecs[i].expLo});
      checkOutput({vecs[i].name, "_busy"}, 64'(busyCnt), 64'(ExpBusy));
      checkOutput({vecs[i].name, "_done"}, 64'(doneCnt), 64'd1);
      checkOutput({vecs[i].name, "_overlap"}, 64'(overlapCnt), 64'd0);
    end

    // Start and WriteHi during an operation are both ignored
    directWrite(32'h11111111, 32'h22222222);
    busyCnt = 0; doneCnt = 0;
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; Signed = 1'b0; A = 32'd6; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busyCnt++;
      if (Done) doneCnt++;
      if (i == 5) begin
        Start = 1'b1; Op = 2'b01; A = 32'd100; B = 32'd100;
        WriteHi = 1'b1; Din = 32'hDEADBEEF;
      end else begin
        Start = 1'b0; WriteHi = 1'b0;
      end
      if (i == 6 && ExpBusy > 6)
        checkOutput("collide_stable", {Hi, Lo}, {32'h11111111, 32'h22222222});
      @(negedge Clk);
    end
    checkOutput("collide_hilo", {Hi, Lo}, {32'd0, 32'd42});
    checkOutput("collide_done", 64'(doneCnt), 64'd1);
    checkOutput("collide_busy", 64'(busyCnt), 64'(ExpBusy));

    // Reset mid-operation discards it with no Done
    directWrite(32'h33333333, 32'h44444444);
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; Signed = 1'b0; A = 32'd3; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checkOutput("abort_hilo", {Hi, Lo}, 64'd0);
    checkOutput("abort_busy", {63'd0, Busy}, 64'd0);
    checkOutput("abort_done", {63'd0, Done}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) doneCnt++;
      @(negedge Clk);
    end
    checkOutput("abort_nodone", 64'(doneCnt), 64'd0);

    // Recovery after abort
    applyStimulus(2'b00, 1'b0, 32'd4, 32'd5, busyCnt, doneCnt, overlapCnt);
    checkOutput("recover_hilo", {Hi, Lo}, {32'd0, 32'd20});
    checkOutput("recover_done", 64'(doneCnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
